seq_alu: RTL

//   Parametrised, registered ALU for the multi-cycle CPU datapath.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_core.sv | 79 +++++++
 rtl/seq_alu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-code encoding, FSM state encoding and op classification for seq_alu.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'd0;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd1;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd3;
  localparam logic [OP_W-1:0] ALU_DIVU = 4'd4;
  localparam logic [OP_W-1:0] ALU_REMU = 4'd5;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'd12;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd14;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'd15;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ITER = 1'b1
  } state_t;

  // Ops handled by the iterative core rather than the single-cycle path.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative MUL / DIVU / REMU datapath, one step per cycle.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          latch op and operands
//   step           perform one shift-add / restoring-subtract step
//   last           parent counter has reached its final step
//   op, src1, src2 op code and operands (sampled on start)
//   done_c         strobe: result_c holds the final result this cycle
//   result_c       result after the current step
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  // Shared registers:
  //   MUL : x = multiplicand (shifts left), y = multiplier (shifts right), z = product
  //   DIV : x = divisor, y = dividend shifting out / quotient shifting in, z = remainder
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] x_n, y_n, z_n;
  logic [WIDTH:0]   part;
  logic             ge;

  // One iteration step.
  always_comb begin
    x_n  = x_q;
    y_n  = y_q;
    z_n  = z_q;
    part = '0;
    ge   = 1'b0;
    if (op_q == ALU_MUL) begin
      z_n = y_q[0] ? (z_q + x_q) : z_q;
      x_n = x_q << 1;
      y_n = y_q >> 1;
    end else begin
      // Divide by zero falls out naturally: every trial succeeds, so the
      // quotient is all ones and the remainder is the dividend.
      part = {z_q, y_q[WIDTH-1]};
      ge   = (part >= {1'b0, x_q});
      z_n  = ge ? WIDTH'(part - {1'b0, x_q}) : part[WIDTH-1:0];
      y_n  = {y_q[WIDTH-2:0], ge};
    end
  end

  // Operand / partial-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
    end else if (start) begin
      op_q <= op;
      x_q  <= (op == ALU_MUL) ? src1 : src2;
      y_q  <= (op == ALU_MUL) ? src2 : src1;
      z_q  <= '0;
    end else if (step) begin
      x_q <= x_n;
      y_q <= y_n;
      z_q <= z_n;
    end
  end

  assign done_c   = step & last;
  assign result_c = (op_q == ALU_DIVU) ? y_n : z_n;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready input handshake and iterative MUL/DIV.
// Ports:
//   clk_i, rst_i        clock, async active-low reset
//   flush_i             synchronous abort of the current op
//   valid_i / ready_o   input handshake (accept = valid_i && ready_o)
//   src1_i, src2_i      operands; ctrl_i op code
//   valid_o             one-cycle pulse when result/flags update
//   result_o            registered result, held between pulses
//   zero_o, less_o      result == 0, result MSB
//   ovf_o               signed overflow for ADD/SUB
//   illegal_o           unassigned op code
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [OP_W-1:0]  ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             less_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic             ready_q;
  logic             start_c, step_c, sc_load_c, iter_op_c, last_c;
  logic             core_done_c;
  logic [WIDTH-1:0] core_result_c;

  logic [WIDTH-1:0] sum_c, diff_c, sc_result_c;
  logic             add_ovf_c, sub_ovf_c, sc_ovf_c, sc_illegal_c;

  logic             valid_q, zero_q, less_q, ovf_q, illegal_q;
  logic [WIDTH-1:0] result_q;

  assign iter_op_c = is_iter_op(ctrl_i);
  assign last_c    = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_i && !flush_i && iter_op_c) state_d = S_ITER;
      S_ITER: if (flush_i || last_c)                state_d = S_IDLE;
      default:                                      state_d = S_IDLE;
    endcase
  end

  // Control outputs of the FSM.
  always_comb begin
    start_c   = 1'b0;
    step_c    = 1'b0;
    sc_load_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          start_c   = iter_op_c;
          sc_load_c = !iter_op_c;
        end
      end
      S_ITER:  step_c = !flush_i;
      default: ;
    endcase
  end

  // Ready mirrors the upcoming state so it rises with the final valid_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ready_q <= 1'b1;
    else        ready_q <= (state_d == S_IDLE);
  end

  // Step counter: WIDTH-1 down to 0 while iterating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     cnt_q <= '0;
    else if (start_c)               cnt_q <= SHW'(WIDTH - 1);
    else if (step_c && !last_c)     cnt_q <= cnt_q - SHW'(1);
    else if (flush_i)               cnt_q <= '0;
  end

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .start    (start_c),
    .step     (step_c),
    .last     (last_c),
    .op       (ctrl_i),
    .src1     (src1_i),
    .src2     (src2_i),
    .done_c   (core_done_c),
    .result_c (core_result_c)
  );

  // Single-cycle datapath.
  assign sum_c     = src1_i + src2_i;
  assign diff_c    = src1_i - src2_i;
  assign add_ovf_c = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum_c[WIDTH-1]  != src1_i[WIDTH-1]);
  assign sub_ovf_c = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff_c[WIDTH-1] != src1_i[WIDTH-1]);

  always_comb begin
    sc_result_c  = '0;
    sc_ovf_c     = 1'b0;
    sc_illegal_c = 1'b0;
    case (ctrl_i)
      ALU_AND: sc_result_c = src1_i & src2_i;
      ALU_OR:  sc_result_c = src1_i | src2_i;
      ALU_ADD: begin
        sc_result_c = sum_c;
        sc_ovf_c    = add_ovf_c;
      end
      ALU_SUB: begin
        sc_result_c = diff_c;
        sc_ovf_c    = sub_ovf_c;
      end
      // Overflow flips the sign of the difference, so correct for it.
      ALU_SLT: sc_result_c = WIDTH'(diff_c[WIDTH-1] ^ sub_ovf_c);
      ALU_NOR: sc_result_c = ~(src1_i | src2_i);
      ALU_SRA: sc_result_c = WIDTH'($signed(src2_i) >>> src1_i[SHW-1:0]);
      ALU_LUI: sc_result_c = src2_i << (WIDTH / 2);
      ALU_MUL, ALU_DIVU, ALU_REMU: sc_result_c = '0;
      default: sc_illegal_c = 1'b1;
    endcase
  end

  // Result and flag registers; only updated on a valid_o cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      less_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= sc_load_c | core_done_c;
      if (sc_load_c) begin
        result_q  <= sc_result_c;
        zero_q    <= (sc_result_c == '0);
        less_q    <= sc_result_c[WIDTH-1];
        ovf_q     <= sc_ovf_c;
        illegal_q <= sc_illegal_c;
      end else if (core_done_c) begin
        result_q  <= core_result_c;
        zero_q    <= (core_result_c == '0);
        less_q    <= core_result_c[WIDTH-1];
        ovf_q     <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign less_o    = less_q;
  assign ovf_o     = ovf_q;
  assign illegal_o = illegal_q;

endmodule
